// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle ALU with single-cycle logic/arith ops and shift-add MUL
//
// Purpose:
//   Registered ALU. AND/OR/NOR/ADD/SUB complete one cycle after Start.
//   MUL runs an iterative shift-and-add multiply and completes after N iterations.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   reset        - synchronous, active-high reset
//   Start        - operation request, sampled only while Busy=0
//   ALUOperation - 4-bit opcode (0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB, 5 MUL, others -> 0)
//   A, B         - 32-bit operands (A multiplicand, B multiplier for MUL)
//   ALUResult    - registered result of the last completed operation
//   Zero         - registered, 1 iff ALUResult==0
//   Busy         - high in every MUL iteration cycle
//   Done         - one-cycle completion pulse, ALUResult valid from this cycle
//
// Configuration:
//   MUL_EARLY_TERM_EN - when defined, MUL stops after the iteration that empties
//                       the shifted multiplier (minimum one iteration); otherwise
//                       MUL always runs 32 iterations. Results are identical.

module multicycle_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  ALUOperation,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Busy,
  output logic        Done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;

  logic [31:0] mcand;     // multiplicand, shifted left each iteration
  logic [31:0] mplier;    // multiplier, shifted right each iteration
  logic [31:0] acc;
  logic [5:0]  count;

  logic [31:0] alu_res;
  logic [31:0] acc_sum;
  logic        mul_last;
  logic        load_alu;
  logic        load_mul;
  logic        mul_step;
  logic        mul_finish;

  // Single-cycle operation result.
  always_comb begin
    alu_res = 32'd0;
    case (ALUOperation)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      default: alu_res = 32'd0;
    endcase
  end

  // Accumulator value after the current iteration; on the final iteration
  // this is the product that goes straight to ALUResult.
  assign acc_sum = acc + (mplier[0] ? mcand : 32'd0);

`ifdef MUL_EARLY_TERM_EN
  // Once the bits above bit0 are clear, this iteration consumes the last set bit.
  assign mul_last = (mplier[31:1] == 31'd0);
`else
  assign mul_last = (count == 6'd31);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    mul_step   = 1'b0;
    mul_finish = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        Done = (state == DONE);
        if (Start) begin
          if (ALUOperation == OP_MUL) begin
            load_mul   = 1'b1;
            state_next = MUL;
          end else begin
            load_alu   = 1'b1;
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      MUL: begin
        Busy     = 1'b1;
        mul_step = 1'b1;
        if (mul_last) begin
          mul_finish = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult <= 32'd0;
      Zero      <= 1'b1;
      mcand     <= 32'd0;
      mplier    <= 32'd0;
      acc       <= 32'd0;
      count     <= 6'd0;
    end else begin
      if (load_alu) begin
        ALUResult <= alu_res;
        Zero      <= (alu_res == 32'd0);
      end
      if (load_mul) begin
        mcand  <= A;
        mplier <= B;
        acc    <= 32'd0;
        count  <= 6'd0;
      end
      if (mul_step) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 6'd1;
      end
      if (mul_finish) begin
        ALUResult <= acc_sum;
        Zero      <= (acc_sum == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking scoreboard bench for multicycle_alu

module tb_multicycle_alu;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  // {result, zero}
  logic [32:0] sb_q[$];

  multicycle_alu dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .ALUResult    (ALUResult),
    .Zero         (Zero),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = ~(a | b);
      4'd3:    r = a + b;
      4'd4:    r = a - b;
      4'd5:    r = a * b;
      default: r = 32'd0;
    endcase
    return {r, (r == 32'd0)};
  endfunction

  function automatic int exp_iters(input logic [31:0] b);
    int n;
    n = 32;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`endif
    return n;
  endfunction

  // Advance to just after the next rising edge; Start is a one-cycle pulse.
  task automatic step();
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start        = 1'b1;
    ALUOperation = op;
    A            = a;
    B            = b;
    sb_q.push_back(model(op, a, b));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b0;
    ALUOperation = 4'd0;
    A = 32'hDEAD_BEEF;
    B = 32'h1234_5678;
    step();
    step();
    checks++;
    if ({ALUResult, Zero, Busy, Done} !== {32'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: got res=%h z=%b busy=%b done=%b expected res=0 z=1 busy=0 done=0",
               ALUResult, Zero, Busy, Done);
    else ;
    if ({ALUResult, Zero, Busy, Done} !== {32'd0, 1'b1, 1'b0, 1'b0}) errors++;
    reset = 1'b0;
  endtask

  // Start lands in the first cycle after reset release.
  task automatic test_add();
    logic [32:0] exp;
    issue(4'b0011, 32'd5, 32'd7);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL add_busy_issue: got %b expected 0", Busy);
    end
    step();
    exp = sb_q.pop_front();
    checks++;
    if ({Done, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL add_done: got done=%b busy=%b expected done=1 busy=0", Done, Busy);
    end
    checks++;
    if ({ALUResult, Zero} !== exp || ALUResult !== 32'd12) begin
      errors++;
      $display("FAIL add_result: got %h z=%b expected %h z=%b", ALUResult, Zero, exp[32:1], exp[0]);
    end
    step();
    checks++;
    if ({Done, ALUResult} !== {1'b0, 32'd12}) begin
      errors++;
      $display("FAIL add_hold: got done=%b res=%h expected done=0 res=0000000c", Done, ALUResult);
    end
  endtask

  task automatic test_sub_illegal();
    logic [32:0] exp;
    issue(4'b0100, 32'd9, 32'd9);
    step();
    exp = sb_q.pop_front();
    checks++;
    if ({Done, ALUResult, Zero} !== {1'b1, exp} || Zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: got done=%b res=%h z=%b expected done=1 res=%h z=%b",
               Done, ALUResult, Zero, exp[32:1], exp[0]);
    end
    step();
    issue(4'b0011, 32'd1, 32'd1);
    step();
    exp = sb_q.pop_front();
    issue(4'b1001, 32'h1234_5678, 32'h0F0F_0F0F);
    step();
    exp = sb_q.pop_front();
    checks++;
    if ({Done, ALUResult, Zero} !== {1'b1, exp} || Zero !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: got done=%b res=%h z=%b expected done=1 res=%h z=%b",
               Done, ALUResult, Zero, exp[32:1], exp[0]);
    end
    step();
  endtask

  task automatic test_logic_ops();
    logic [32:0] exp;
    logic [3:0]  op;
    for (int k = 0; k < 10; k++) begin
      op = 4'(k % 5);
      issue(op, $urandom, (k == 9) ? 32'hFFFF_FFFF : $urandom);
      step();
      exp = sb_q.pop_front();
      checks++;
      if ({Done, Busy, ALUResult, Zero} !== {2'b10, exp}) begin
        errors++;
        $display("FAIL op_%0d[%0d]: got done=%b busy=%b res=%h z=%b expected res=%h z=%b",
                 op, k, Done, Busy, ALUResult, Zero, exp[32:1], exp[0]);
      end
      step();
    end
  endtask

  task automatic test_mul();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [32:0] exp;
    logic [31:0] prev;
    logic        held;
    int          n, busy_cnt, done_at;
    ta[0] = 32'h0001_0003; tb[0] = 32'h0001_0000;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;
    ta[2] = 32'd12345;     tb[2] = 32'd0;
    ta[3] = $urandom;      tb[3] = 32'd1;
    ta[4] = $urandom;      tb[4] = $urandom;
    for (int k = 0; k < 5; k++) begin
      prev = ALUResult;
      n = exp_iters(tb[k]);
      issue(4'b0101, ta[k], tb[k]);
      busy_cnt = 0;
      done_at = 0;
      held = 1'b1;
      for (int c = 1; c <= 40 && done_at == 0; c++) begin
        step();
        if (Busy) busy_cnt++;
        if (Done) done_at = c;
        else if (ALUResult !== prev) held = 1'b0;
      end
      exp = sb_q.pop_front();
      checks++;
      if (done_at != n + 1) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got done at +%0d expected +%0d", k, done_at, n + 1);
      end
      checks++;
      if (busy_cnt != n) begin
        errors++;
        $display("FAIL mul_busy[%0d]: got %0d busy cycles expected %0d", k, busy_cnt, n);
      end
      checks++;
      if ({ALUResult, Zero} !== exp) begin
        errors++;
        $display("FAIL mul_result[%0d]: got %h z=%b expected %h z=%b", k, ALUResult, Zero, exp[32:1], exp[0]);
      end
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL mul_hold[%0d]: result changed before Done, expected held %h", k, prev);
      end
      step();
    end
  endtask

  task automatic test_mul_ignore();
    logic [32:0] exp;
    int          dones;
    issue(4'b0101, 32'h0000_1234, 32'h0000_5678);
    step();
    step();
    step();
    Start = 1'b1;
    ALUOperation = 4'b0011;
    A = 32'hAAAA_AAAA;
    B = 32'h5555_5555;
    step();
    A = 32'h1111_1111;
    B = 32'h2222_2222;
    dones = 0;
    for (int c = 0; c < 45; c++) begin
      if (Done) dones++;
      step();
    end
    exp = sb_q.pop_front();
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL mul_ignore_dones: got %0d expected 1", dones);
    end
    checks++;
    if ({ALUResult, Zero} !== exp) begin
      errors++;
      $display("FAIL mul_ignore_result: got %h z=%b expected %h z=%b", ALUResult, Zero, exp[32:1], exp[0]);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    issue(4'b0101, 32'h0000_0007, 32'hFFFF_FFFF);
    void'(sb_q.pop_back());
    for (int c = 0; c < 10; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({Busy, Done, ALUResult, Zero} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b res=%h z=%b expected busy=0 done=0 res=0 z=1",
               Busy, Done, ALUResult, Zero);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (Done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d Done pulses expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    issue(4'b0011, 32'd1, 32'd2);
    step();
    exp = sb_q.pop_front();
    checks++;
    if ({Done, ALUResult, Zero} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL b2b_first: got done=%b res=%h expected done=1 res=%h", Done, ALUResult, exp[32:1]);
    end
    issue(4'b0010, 32'd0, 32'd0);
    step();
    exp = sb_q.pop_front();
    checks++;
    if ({Done, ALUResult, Zero} !== {1'b1, exp} || ALUResult !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL b2b_nor: got done=%b res=%h z=%b expected done=1 res=%h z=%b",
               Done, ALUResult, Zero, exp[32:1], exp[0]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_illegal();
    test_logic_ops();
    test_mul();
    test_mul_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
